blood_ph_monitor: RTL and testbench

//   Sequential, parametrised blood-pH monitor for the patient-health datapath. Accepts
//   pH samples on a valid strobe, classifies each as LOW/NORMAL/HIGH/FAULT against

---
 rtl/blood_ph_monitor.sv | 184 ++++++++++++++++++
 tb/tb_blood_ph_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/blood_ph_monitor.sv
// Blood-pH monitor: classifies each valid pH sample as LOW/NORMAL/HIGH/FAULT,
// confirms acidosis (abnormalityP) or alkalosis (abnormalityQ) after a run of
// CONFIRM_CNT same-direction samples, and releases an alarm after CLEAR_CNT
// consecutive normal samples. FAULT samples are counted and otherwise ignored.
module blood_ph_monitor #(
  parameter int PH_W        = 4,
  parameter int LOW_TH      = 7,
  parameter int HIGH_TH     = 8,
  parameter int PH_MAX      = 14,
  parameter int CONFIRM_CNT = 3,
  parameter int CLEAR_CNT   = 2,
  parameter int FAULT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PH_W-1:0]    bloodPH,
  input  logic               sampleValid,
  output logic               abnormalityP,
  output logic               abnormalityQ,
  output logic               alarmEvent,
  output logic               sensorFault,
  output logic [FAULT_W-1:0] faultCount
);

  localparam int RUN_MAX = (CONFIRM_CNT > CLEAR_CNT) ? CONFIRM_CNT : CLEAR_CNT;
  localparam int CNT_W   = $clog2(RUN_MAX + 1);

  localparam logic [CNT_W-1:0]   CONFIRM_V = CNT_W'(CONFIRM_CNT);
  localparam logic [CNT_W-1:0]   CLEAR_V   = CNT_W'(CLEAR_CNT);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FAULT_W-1:0] FC_ONE    = FAULT_W'(1);

  typedef enum logic [2:0] {
    NORMAL,
    SUSP_LOW,
    SUSP_HIGH,
    ALARM_LOW,
    ALARM_HIGH
  } stateT;

  typedef enum logic [1:0] {
    CLS_LOW,
    CLS_NORMAL,
    CLS_HIGH,
    CLS_FAULT
  } sampleClassT;

  // With a single-sample confirmation a run starts directly in the alarm state.
  localparam stateT           LOW_ENTRY  = (CONFIRM_CNT == 1) ? ALARM_LOW  : SUSP_LOW;
  localparam stateT           HIGH_ENTRY = (CONFIRM_CNT == 1) ? ALARM_HIGH : SUSP_HIGH;
  localparam logic [CNT_W-1:0] ENTRY_CNT = (CONFIRM_CNT == 1) ? '0 : CNT_ONE;

  stateT           state;
  stateT           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [CNT_W-1:0] cntInc;
  sampleClassT     sampleClass;
  int              sampleVal;

  assign sampleVal = int'(bloodPH);
  assign cntInc    = cnt + CNT_ONE;

  // Classify the incoming sample; FAULT takes precedence over LOW/HIGH.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sampleClass = CLS_NORMAL;
    if (sampleVal > PH_MAX)       sampleClass = CLS_FAULT;
    else if (sampleVal < LOW_TH)  sampleClass = CLS_LOW;
    else if (sampleVal > HIGH_TH) sampleClass = CLS_HIGH;
  end

  // Next state and run counter for an accepted non-fault sample.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (sampleValid && sampleClass != CLS_FAULT) begin
      unique case (state)
        NORMAL, SUSP_LOW, SUSP_HIGH: begin
          unique case (sampleClass)
            CLS_LOW: begin
              if (state == SUSP_LOW) begin
                if (cntInc == CONFIRM_V) begin
                  stateNext = ALARM_LOW;
                  cntNext   = '0;
                end else begin
                  cntNext = cntInc;
                end
              end else begin
                stateNext = LOW_ENTRY;
                cntNext   = ENTRY_CNT;
              end
            end
            CLS_HIGH: begin
              if (state == SUSP_HIGH) begin
                if (cntInc == CONFIRM_V) begin
                  stateNext = ALARM_HIGH;
                  cntNext   = '0;
                end else begin
                  cntNext = cntInc;
                end
              end else begin
                stateNext = HIGH_ENTRY;
                cntNext   = ENTRY_CNT;
              end
            end
            default: begin
              stateNext = NORMAL;
              cntNext   = '0;
            end
          endcase
        end
        ALARM_LOW: begin
          unique case (sampleClass)
            CLS_LOW: cntNext = '0;
            CLS_HIGH: begin
              stateNext = HIGH_ENTRY;
              cntNext   = ENTRY_CNT;
            end
            default: begin
              if (cntInc == CLEAR_V) begin
                stateNext = NORMAL;
                cntNext   = '0;
              end else begin
                cntNext = cntInc;
              end
            end
          endcase
        end
        ALARM_HIGH: begin
          unique case (sampleClass)
            CLS_HIGH: cntNext = '0;
            CLS_LOW: begin
              stateNext = LOW_ENTRY;
              cntNext   = ENTRY_CNT;
            end
            default: begin
              if (cntInc == CLEAR_V) begin
                stateNext = NORMAL;
                cntNext   = '0;
              end else begin
                cntNext = cntInc;
              end
            end
          endcase
        end
        default: begin
          stateNext = NORMAL;
          cntNext   = '0;
        end
      endcase
    end
  end

  // State register plus registered alarm, event and fault outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= NORMAL;
      cnt          <= '0;
      abnormalityP <= 1'b0;
      abnormalityQ <= 1'b0;
      alarmEvent   <= 1'b0;
      sensorFault  <= 1'b0;
      faultCount   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      alarmEvent  <= 1'b0;
      sensorFault <= 1'b0;
      if (sampleValid) begin
        state        <= stateNext;
        cnt          <= cntNext;
        abnormalityP <= (stateNext == ALARM_LOW);
        abnormalityQ <= (stateNext == ALARM_HIGH);
        alarmEvent   <= ((stateNext == ALARM_LOW)  && !abnormalityP) ||
                        ((stateNext == ALARM_HIGH) && !abnormalityQ);
        if (sampleClass == CLS_FAULT) begin
          sensorFault <= 1'b1;
          if (faultCount != '1) faultCount <= faultCount + FC_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_blood_ph_monitor.sv
// Scoreboard bench for blood_ph_monitor: the driver pushes the expected
// response of every cycle into a queue, a separate monitor pops and compares
// after each rising edge. The reference model works on the history of samples.
module tb_blood_ph_monitor;

  localparam int LOW_TH      = 7;
  localparam int HIGH_TH     = 8;
  localparam int PH_MAX      = 14;
  localparam int CONFIRM_CNT = 3;
  localparam int CLEAR_CNT   = 2;
  localparam int FC_MAX      = 255;

  localparam int C_LOW = 0, C_NORM = 1, C_HIGH = 2, C_FAULT = 3;

  typedef struct {
    logic       p;
    logic       q;
    logic       evt;
    logic       flt;
    logic [7:0] fc;
  } expT;

  logic       clk;
  logic       rst_n;
  logic [3:0] bloodPH;
  logic       sampleValid;
  logic       abnormalityP;
  logic       abnormalityQ;
  logic       alarmEvent;
  logic       sensorFault;
  logic [7:0] faultCount;

  int  compared   = 0;
  int  mismatched = 0;
  expT expQ[$];

  // Reference model state: recent non-fault sample classes, current alarm
  // direction (0 none, 1 low, 2 high) and total faults since reset.
  int histQ[$];
  int alarmDir   = 0;
  int faultTotal = 0;

  blood_ph_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bloodPH     (bloodPH),
    .sampleValid (sampleValid),
    .abnormalityP(abnormalityP),
    .abnormalityQ(abnormalityQ),
    .alarmEvent  (alarmEvent),
    .sensorFault (sensorFault),
    .faultCount  (faultCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input int ph);
    if (ph > PH_MAX)  return C_FAULT;
    if (ph < LOW_TH)  return C_LOW;
    if (ph > HIGH_TH) return C_HIGH;
    return C_NORM;
  endfunction

  function automatic bit lastAll(input int cls, input int n);
    if (histQ.size() < n) return 1'b0;
    for (int i = histQ.size() - n; i < histQ.size(); i++)
      if (histQ[i] != cls) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    histQ.delete();
    alarmDir   = 0;
    faultTotal = 0;
  endtask

  // An alarm is active while its run is confirmed; it ends on an opposite
  // sample or after CLEAR_CNT trailing normal samples.
  task automatic modelStep(input logic v, input int ph, output expT e);
    int prev;
    int cls;
    e.evt = 1'b0;
    e.flt = 1'b0;
    if (v) begin
      cls = classify(ph);
      if (cls == C_FAULT) begin
        e.flt = 1'b1;
        faultTotal++;
      end else begin
        histQ.push_back(cls);
        if (histQ.size() > 16) void'(histQ.pop_front());
        prev = alarmDir;
        if (alarmDir == 1 && (cls == C_HIGH || lastAll(C_NORM, CLEAR_CNT))) alarmDir = 0;
        if (alarmDir == 2 && (cls == C_LOW  || lastAll(C_NORM, CLEAR_CNT))) alarmDir = 0;
        if (alarmDir == 0) begin
          if (lastAll(C_LOW, CONFIRM_CNT))       alarmDir = 1;
          else if (lastAll(C_HIGH, CONFIRM_CNT)) alarmDir = 2;
        end
        e.evt = (alarmDir != 0) && (alarmDir != prev);
      end
    end
    e.p  = (alarmDir == 1);
    e.q  = (alarmDir == 2);
    e.fc = 8'((faultTotal > FC_MAX) ? FC_MAX : faultTotal);
  endtask

  task automatic send(input logic v, input int ph);
    expT e;
    @(negedge clk);
    sampleValid = v;
    bloodPH     = 4'(ph);
    modelStep(v, ph, e);
    expQ.push_back(e);
  endtask

  task automatic sendSeq(input int seq[$]);
    foreach (seq[i]) send(1'b1, seq[i]);
  endtask

  task automatic drain();
    int guard = 0;
    while (expQ.size() > 0 && guard < 20) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("drain_queue_empty", expQ.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_P"},   abnormalityP, 0);
    check({tag, "_Q"},   abnormalityQ, 0);
    check({tag, "_evt"}, alarmEvent,   0);
    check({tag, "_flt"}, sensorFault,  0);
    check({tag, "_fc"},  faultCount,   0);
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic doReset(input string tag);
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    sampleValid = 1'b0;
    #1;
    checkAllZero(tag);
    modelReset();
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int phFor(input int cls);
    case (cls)
      C_LOW:   return $urandom_range(0, LOW_TH - 1);
      C_HIGH:  return $urandom_range(HIGH_TH + 1, PH_MAX);
      C_FAULT: return $urandom_range(PH_MAX + 1, 15);
      default: return $urandom_range(LOW_TH, HIGH_TH);
    endcase
  endfunction

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        e = expQ.pop_front();
        check("abnormalityP", abnormalityP, e.p);
        check("abnormalityQ", abnormalityQ, e.q);
        check("alarmEvent",   alarmEvent,   e.evt);
        check("sensorFault",  sensorFault,  e.flt);
        check("faultCount",   faultCount,   e.fc);
        check("never_both",   abnormalityP & abnormalityQ, 0);
      end
    end
  end

  initial begin
    int cls;
    rst_n       = 1'b0;
    sampleValid = 1'b0;
    bloodPH     = '0;
    #12;
    checkAllZero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Confirmation, broken run, release.
    sendSeq('{5, 5, 5, 7, 7});
    sendSeq('{5, 5, 7, 5, 5, 7});
    // High alarm and interrupted clearing.
    sendSeq('{10, 10, 10, 10, 7, 10, 7, 7});
    // Direction swap out of a low alarm.
    sendSeq('{5, 5, 5, 9, 9, 9, 7, 7});
    // Reset mid-run discards the partial count.
    sendSeq('{5, 5});
    doReset("rst_mid");
    sendSeq('{5, 5, 7});
    // Fault does not break a run.
    doReset("rst_fault");
    sendSeq('{5, 15, 5, 5, 7, 7});
    // Fault counter saturation.
    repeat (300) send(1'b1, 15);
    drain();
    check("fc_saturated", faultCount, FC_MAX);
    // Gaps in sampleValid, then boundary values.
    send(1'b1, 5);
    repeat (10) send(1'b0, $urandom_range(0, 6));
    sendSeq('{5, 5, 7, 8, 7, 8, 8, 7, 14, 0});

    // Randomized runs with sticky classes, gaps and occasional resets.
    cls = C_NORM;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 30) cls = ($urandom_range(0, 99) < 10) ? C_FAULT : $urandom_range(0, 2);
      send($urandom_range(0, 99) < 80, phFor(cls));
      if (i == 200 || i == 400) doReset("rst_rand");
    end

    send(1'b0, 0);
    send(1'b0, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
